fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised synchronous FIFO: DATA_W-bit words, 2**ADDR_W entries. Single clock.
//  A 3-bit state machine and registered head/tail/count/dout, each reset asynchronously to 0.
//  Replaces fixed 8x32 FIFO instances; sits between a producer and a consumer on the same clk.
// PARAMETERS
//  DATA_W  32  word width (bits)
//  ADDR_W  3   address width; DEPTH = 2**ADDR_W entries (min ADDR_W=1)
// PORTS
//  clk         in   1         rising-edge clock
//  reset_n     in   1         asynchronous, active-low reset
//  wr_en       in   1         write request, sampled at rising edge
//  din         in   DATA_W    write data, sampled with wr_en
//  rd_en       in   1         read request, sampled at rising edge
//  dout        out  DATA_W    registered read data
//  data_count  out  ADDR_W+1  number of stored words, 0..DEPTH
//  full        out  1         data_count==DEPTH (combinational from count register)
//  empty       out  1         data_count==0 (combinational from count register)
//  wr_ack      out  1         registered: last sampled write accepted
//  wr_err      out  1         registered: last sampled write rejected (full)
//  rd_ack      out  1         registered: last sampled read accepted
//  rd_err      out  1         registered: last sampled read rejected (empty)
// BEHAVIOUR
//  - Reset (any time, incl. mid-transfer): state=INIT, head=tail=0, count=0, dout=0,
//    all ack/err=0, empty=1, full=0. Memory contents are not cleared (don't care).
//  - States (3-bit): INIT, NO_OP, WRITE, WR_ERR, READ, RD_ERR (+ RDWR, see CONFIGURATION).
//    State is recomputed every edge from wr_en/rd_en/count. It never holds across cycles.
//    State INIT is left on the first edge after reset release.
//  - Latency: a request sampled at edge N updates mem/tail/head/count/dout at edge N.
//    The ack/err flag for that request is valid in the cycle after edge N, for one cycle only.
//  - Decode at edge (no simultaneous request):
//    wr_en & !full  -> WRITE:  mem[tail]<=din, tail<=tail+1, count+1, wr_ack=1
//    wr_en & full   -> WR_ERR: no change, wr_err=1
//    rd_en & !empty -> READ:   dout<=mem[head], head<=head+1, count-1, rd_ack=1
//    rd_en & empty  -> RD_ERR: no change, dout holds, rd_err=1
//    neither        -> NO_OP:  all flags 0, dout holds
//  - Pointers are ADDR_W bits and wrap DEPTH-1 -> 0 modulo 2**ADDR_W.
//    Full/empty are decided only by count, never by pointer compare.
//  - count saturates logically: it cannot exceed DEPTH or go below 0 (error paths block it).
//  - dout holds its last read value in every state other than READ/RDWR.
//  - At most one of wr_ack/wr_err is set per cycle; likewise for rd_ack/rd_err.
// CONFIGURATION
//  Macro FIFO_SIMUL_RW_EN.
//  Undefined: wr_en&rd_en -> read has priority. The read is decoded as above; the write is
//    dropped silently (wr_ack=0, wr_err=0). No RDWR state exists.
//  Defined: wr_en&rd_en -> RDWR state:
//    !empty -> write and read both done, count unchanged, wr_ack=rd_ack=1
//              (full case included: the read frees the slot).
//    empty  -> write done (count+1, wr_ack=1), read rejected (rd_err=1, dout holds).
// TESTING
//  1 reset, idle 3 cycles -> dout=0, count=0, empty=1, full=0, all flags 0
//  2 8 writes 0x11..0x88 (ADDR_W=3) -> wr_ack each cycle, full=1 after 8th
//    9th write 0x99 -> wr_err=1, count stays 8
//  3 8 reads -> dout=0x11..0x88 in order, empty=1; 9th read -> rd_err=1, dout stays 0x88
//  4 wrap: write 5, read 5, write 6, read 6 -> data order preserved
//    tail and head pass 7->0, count returns to 0
//  5 wr_en&rd_en with count=3 -> macro off: read only, count=2, wr_ack=0;
//    macro on: count=3, both acks=1
//  6 reset_n low mid-burst (count=4) -> immediately count=0, dout=0, flags 0
//    after release: the next write lands at address 0

Source files
------------

// File: rtl/fifo_sync_param.sv
// Purpose : parametrised single-clock FIFO, DATA_W-bit words, 2**ADDR_W entries.
// Latency : a request sampled at edge N updates storage/count/dout at edge N; its ack/err is seen the cycle after.
// Backpr. : none; writes when full and reads when empty are rejected and flagged with wr_err/rd_err.
//
// Ports:
//   clk, reset_n (async, active-low)
//   wr_en, din          write request and data
//   rd_en               read request
//   dout                registered read data, holds between reads
//   data_count          stored words, 0..DEPTH
//   full, empty         decoded from the count register
//   wr_ack/wr_err       outcome of the last sampled write (one cycle)
//   rd_ack/rd_err       outcome of the last sampled read (one cycle)
//
// Optional feature macro: FIFO_SIMUL_RW_EN
//   undefined: simultaneous write+read performs the read only, write dropped silently.
//   defined  : simultaneous write+read performs both (RDWR state).
module fifo_sync_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_NO_OP  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WR_ERR = 3'd3,
        ST_READ   = 3'd4,
        ST_RD_ERR = 3'd5
`ifdef FIFO_SIMUL_RW_EN
        , ST_RDWR = 3'd6
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   head_q, head_d;
    logic [ADDR_W-1:0]   tail_q, tail_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                do_wr, do_rd;
    // RDWR on an empty FIFO: the write goes in, the read is refused.
    logic                rdwr_nord_q, rdwr_nord_d;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Next-state decode; the state is a pure function of the current request,
    // so it is recomputed every edge and never holds.
    always_comb begin
        state_d     = ST_NO_OP;
        do_wr       = 1'b0;
        do_rd       = 1'b0;
        rdwr_nord_d = 1'b0;
        if (wr_en && rd_en) begin
`ifdef FIFO_SIMUL_RW_EN
            state_d     = ST_RDWR;
            do_wr       = 1'b1;       // even when full: the read frees the slot
            do_rd       = !empty;
            rdwr_nord_d = empty;
`else
            // Read wins; the write is dropped without any flag.
            state_d = empty ? ST_RD_ERR : ST_READ;
            do_rd   = !empty;
`endif
        end else if (wr_en) begin
            state_d = full ? ST_WR_ERR : ST_WRITE;
            do_wr   = !full;
        end else if (rd_en) begin
            state_d = empty ? ST_RD_ERR : ST_READ;
            do_rd   = !empty;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (do_wr) begin
            tail_d = tail_q + 1'b1;
        end
        if (do_rd) begin
            head_d = head_q + 1'b1;
            dout_d = mem_q[head_q];
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            rdwr_nord_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            rdwr_nord_q <= rdwr_nord_d;
        end
    end

    // Storage is not reset; contents are only meaningful behind the count.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[tail_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign data_count = count_q;

    // Flags are decoded from the registered state, so each lasts exactly one cycle.
    always_comb begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
        case (state_q)
            ST_WRITE:  wr_ack = 1'b1;
            ST_WR_ERR: wr_err = 1'b1;
            ST_READ:   rd_ack = 1'b1;
            ST_RD_ERR: rd_err = 1'b1;
`ifdef FIFO_SIMUL_RW_EN
            ST_RDWR: begin
                wr_ack = 1'b1;
                rd_ack = !rdwr_nord_q;
                rd_err = rdwr_nord_q;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] din = '0;
    logic        rd_en = 1'b0;
    logic [31:0] dout;
    logic [3:0]  data_count;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;

    int checks = 0;
    int errors = 0;

    // Scoreboard: words pushed on accepted writes, popped on accepted reads.
    logic [31:0] sb_q[$];
    logic [31:0] exp_dout = '0;
    logic        e_wa, e_we, e_ra, e_re;

    fifo_sync_param #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .data_count(data_count), .full(full), .empty(empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"},   64'(dout), 64'(exp_dout));
        chk({tag, ".count"},  64'(data_count), 64'(sb_q.size()));
        chk({tag, ".full"},   64'(full), 64'(sb_q.size() == 8));
        chk({tag, ".empty"},  64'(empty), 64'(sb_q.size() == 0));
        chk({tag, ".wr_ack"}, 64'(wr_ack), 64'(e_wa));
        chk({tag, ".wr_err"}, 64'(wr_err), 64'(e_we));
        chk({tag, ".rd_ack"}, 64'(rd_ack), 64'(e_ra));
        chk({tag, ".rd_err"}, 64'(rd_err), 64'(e_re));
    endtask

    // One clock of stimulus: model predicts, DUT is driven, then compared #1 after the edge.
    task automatic step(input string tag, input logic w, input logic [31:0] d, input logic r);
        bit was_empty, was_full;
        was_empty = (sb_q.size() == 0);
        was_full  = (sb_q.size() == 8);
        e_wa = 0; e_we = 0; e_ra = 0; e_re = 0;
        if (w && r) begin
`ifdef FIFO_SIMUL_RW_EN
            if (!was_empty) begin
                exp_dout = sb_q.pop_front();
                e_ra = 1;
            end else begin
                e_re = 1;
            end
            sb_q.push_back(d);
            e_wa = 1;
`else
            if (!was_empty) begin
                exp_dout = sb_q.pop_front();
                e_ra = 1;
            end else begin
                e_re = 1;
            end
`endif
        end else if (w) begin
            if (!was_full) begin
                sb_q.push_back(d);
                e_wa = 1;
            end else begin
                e_we = 1;
            end
        end else if (r) begin
            if (!was_empty) begin
                exp_dout = sb_q.pop_front();
                e_ra = 1;
            end else begin
                e_re = 1;
            end
        end
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
        wr_en = 0;
        rd_en = 0;
        chk_all(tag);
    endtask

    initial begin
        logic [31:0] v;
        e_wa = 0; e_we = 0; e_ra = 0; e_re = 0;

        // 1: reset, then idle
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0);

        // 2: fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            v = 32'h11 * i;
            step("fill", 1, v, 0);
        end
        step("overflow", 1, 32'h99, 0);

        // 3: drain, then underflow (dout must hold 0x88)
        for (int i = 0; i < 8; i++) step("drain", 0, 0, 1);
        step("underflow", 0, 0, 1);
        chk("underflow.dout_hold", 64'(dout), 64'h88);

        // 4: pointer wrap
        for (int i = 0; i < 5; i++) step("wrap_w5", 1, 32'hA000 + i, 0);
        for (int i = 0; i < 5; i++) step("wrap_r5", 0, 0, 1);
        for (int i = 0; i < 6; i++) step("wrap_w6", 1, 32'hB000 + i, 0);
        for (int i = 0; i < 6; i++) step("wrap_r6", 0, 0, 1);

        // 5: simultaneous write+read at count 3, then at empty and at full
        for (int i = 0; i < 3; i++) step("sim_pre", 1, 32'hC000 + i, 0);
        step("sim_rw3", 1, 32'hC0DE, 1);
        while (sb_q.size() > 0) step("sim_drain", 0, 0, 1);
        step("sim_rw_empty", 1, 32'hD00D, 1);
        while (sb_q.size() < 8) step("sim_fill", 1, 32'hE000 + sb_q.size(), 0);
        step("sim_rw_full", 1, 32'hF00F, 1);
        while (sb_q.size() > 0) step("sim_drain2", 0, 0, 1);

        // 6: async reset mid-burst
        for (int i = 0; i < 4; i++) step("burst", 1, 32'h5500 + i, 0);
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        exp_dout = '0;
        e_wa = 0; e_we = 0; e_ra = 0; e_re = 0;
        chk_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst_init");
        step("post_rst_wr", 1, 32'h1234_5678, 0);
        chk("post_rst_addr0", 64'(dut.mem_q[0]), 64'h1234_5678);
        step("post_rst_rd", 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
